// File: rtl/mem_write_d_pkg.sv
// Shared types for the D-matrix BRAM write frame: the frame FSM encoding and
// the position of the ping-pong bank bit inside a write address.
package mem_write_d_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // The bank bit sits this many positions below the top of the address.
  localparam int BANK_OFS = 1;

  function automatic int bank_bit_of(input int addr_w);
    return addr_w - BANK_OFS;
  endfunction

endpackage

// File: rtl/mem_write_d_lane.sv
// One D-matrix write lane: word counter, lane-done flag, overflow detect and
// the registered BRAM write port. Bank port exists only with MEM_WRITE_D_PINGPONG_EN.
module mem_write_d_lane
  import mem_write_d_pkg::*;
#(
  parameter int D_W          = 32,
  parameter int MATRIXSIZE_W = 16,
  parameter int ADDR_W       = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    run,
  input  logic [MATRIXSIZE_W-1:0] len,
  input  logic [ADDR_W-1:0]       base,
`ifdef MEM_WRITE_D_PINGPONG_EN
  input  logic                    bank,
`endif
  input  logic                    valid,
  input  logic signed [D_W-1:0]   data,
  output logic [ADDR_W-1:0]       wr_addr,
  output logic signed [D_W-1:0]   wr_data,
  output logic                    wr_en,
  output logic                    done,
  output logic                    last,
  output logic                    overflow
);

  logic [MATRIXSIZE_W-1:0] cnt;
  logic [ADDR_W-1:0]       sum;
  logic [ADDR_W-1:0]       addr_nxt;
  logic                    accept;

  assign accept   = valid && run && !done;
  assign last     = accept && (cnt == len - 1'b1);
  assign overflow = valid && !(run && !done);
  assign sum      = base + ADDR_W'(cnt);

`ifdef MEM_WRITE_D_PINGPONG_EN
  localparam int BANK_IDX = bank_bit_of(ADDR_W);
  assign addr_nxt = {bank, sum[BANK_IDX-1:0]};
`else
  assign addr_nxt = sum;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (clear) begin
      cnt  <= '0;
      done <= 1'b0;
    end else if (accept) begin
      cnt <= cnt + 1'b1;
      if (last) done <= 1'b1;
    end
  end

  // Address and data hold on a rejected cycle; only the enable drops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
    end else begin
      wr_en <= accept;
      if (accept) begin
        wr_addr <= addr_nxt;
        wr_data <= data;
      end
    end
  end

endmodule

// File: rtl/mem_write_d_frame.sv
// Frame controller and N1-lane write port for the D-matrix BRAM banks.
// Define MEM_WRITE_D_PINGPONG_EN to alternate between two buffer halves per frame.
module mem_write_d_frame
  import mem_write_d_pkg::*;
#(
  parameter int D_W          = 32,
  parameter int N1           = 4,
  parameter int MATRIXSIZE_W = 16,
  parameter int ADDR_W       = 12
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [MATRIXSIZE_W-1:0] cfg_len,
  input  logic [ADDR_W-1:0]       cfg_base,
  input  logic                    start,
  input  logic                    auto_restart,
  input  logic                    err_clr,
  input  logic [N1-1:0]           in_valid,
  input  logic signed [D_W-1:0]   in_data      [N1],
  output logic [ADDR_W-1:0]       wr_addr_bram [N1],
  output logic signed [D_W-1:0]   wr_data_bram [N1],
  output logic [N1-1:0]           wr_en_bram,
  output logic                    busy,
  output logic                    frame_done,
  output logic                    rd_bank,
  output logic                    err_overflow
);

  state_t                  state, state_nxt;
  logic [MATRIXSIZE_W-1:0] len_q;
  logic [ADDR_W-1:0]       base_q;
  logic [N1-1:0]           lane_done, lane_last, lane_ovf;
  logic                    clear, run, all_done;

  assign run      = (state == ST_RUN);
  assign clear    = ((state == ST_IDLE) && start) || (state == ST_DONE);
  assign all_done = &(lane_done | lane_last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default first so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start) state_nxt = (cfg_len == '0) ? ST_DONE : ST_RUN;
      ST_RUN:  if (all_done) state_nxt = ST_DONE;
      // A zero-length frame on restart has nothing to write; close it at once.
      ST_DONE: if (auto_restart) state_nxt = (len_q == '0) ? ST_DONE : ST_RUN;
               else              state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign busy       = (state != ST_IDLE);
  assign frame_done = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      len_q  <= '0;
      base_q <= '0;
    end else if ((state == ST_IDLE) && start) begin
      len_q  <= cfg_len;
      base_q <= cfg_base;
    end
  end

  // Set wins over clear so a violation in the clearing cycle is not lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          err_overflow <= 1'b0;
    else if (|lane_ovf)  err_overflow <= 1'b1;
    else if (err_clr)    err_overflow <= 1'b0;
  end

`ifdef MEM_WRITE_D_PINGPONG_EN
  logic bank;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                bank <= 1'b0;
    else if (state == ST_DONE) bank <= ~bank;
  end

  assign rd_bank = ~bank;
`else
  assign rd_bank = 1'b0;
`endif

  for (genvar g = 0; g < N1; g++) begin : g_lane
    mem_write_d_lane #(
      .D_W          (D_W),
      .MATRIXSIZE_W (MATRIXSIZE_W),
      .ADDR_W       (ADDR_W)
    ) u_lane (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (clear),
      .run      (run),
      .len      (len_q),
      .base     (base_q),
`ifdef MEM_WRITE_D_PINGPONG_EN
      .bank     (bank),
`endif
      .valid    (in_valid[g]),
      .data     (in_data[g]),
      .wr_addr  (wr_addr_bram[g]),
      .wr_data  (wr_data_bram[g]),
      .wr_en    (wr_en_bram[g]),
      .done     (lane_done[g]),
      .last     (lane_last[g]),
      .overflow (lane_ovf[g])
    );
  end

endmodule

// File: doc/mem_write_d_frame.md
Name: mem_write_d_frame

Overview:
Multi-channel write-address generator and write port for the output-matrix (D) BRAM banks of the systolic matrix-multiply array. It accepts N1 independent result lanes and turns each accepted word into a registered BRAM write. Each lane's address runs from a programmable base over a programmable frame length. A frame controller tracks per-lane completion, reports frame completion and overflow errors, and optionally ping-pongs between two buffer halves so the reader can drain one half while the array fills the other.

Parameters:
D_W, 32, data width per lane
N1, 4, number of lanes / BRAM banks
MATRIXSIZE_W, 16, width of frame-length config and per-lane counters
ADDR_W, 12, BRAM address width (includes bank bit when ping-pong is enabled)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cfg_len  in  MATRIXSIZE_W  words per lane per frame (M1*M3/N1); sampled on accepted start
cfg_base  in  ADDR_W  base address per lane; sampled on accepted start
start  in  1  begin a frame; honoured only in IDLE
auto_restart  in  1  on frame end, go straight back to RUN with the latched config
err_clr  in  1  clears err_overflow
in_valid  in  N1  per-lane write request
in_data  in  N1 x D_W signed  per-lane data
wr_addr_bram  out  N1 x ADDR_W  registered write address
wr_data_bram  out  N1 x D_W signed  registered write data
wr_en_bram  out  N1  registered write enable
busy  out  1  high in RUN and DONE
frame_done  out  1  one-cycle pulse at frame end
rd_bank  out  1  buffer half that is safe to read (the one not being written)
err_overflow  out  1  sticky error flag

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE; all counters, lane_done flags, wr_en_bram, wr_addr_bram, wr_data_bram, frame_done and err_overflow go to 0.
  - Write bank goes to 0 and rd_bank to 1.
  - Reset during a frame abandons the frame; no frame_done is produced.
- FSM states:
  - IDLE: on start, latch cfg_len and cfg_base, clear lane counters and lane_done, go to RUN. If the latched len is 0, go to DONE instead.
  - RUN: a lane accepts a write when in_valid[x]=1 and lane_done[x]=0. When a lane accepts its (len-1)th count, set lane_done[x]. When all lane_done bits are set (including in the cycle the last bit sets), go to DONE next cycle.
  - DONE (exactly 1 cycle):
    - frame_done=1; toggle the write bank (ping-pong build only).
    - If auto_restart=1, clear counters and lane_done and go to RUN; otherwise go to IDLE.
- Write path, latency 1:
  - For an accepted write, the next cycle has wr_en_bram[x]=1, wr_data_bram[x]=in_data[x] from the request cycle, and wr_addr_bram[x]=base+count.
  - The address sum is truncated to ADDR_W (modulo wrap). Counters increment by 1 per accepted write.
  - A rejected write gives wr_en_bram[x]=0; wr_addr_bram and wr_data_bram hold their previous values.
- Overflow:
  - err_overflow is set by in_valid[x]=1 in IDLE, by in_valid[x]=1 in DONE, or by in_valid[x]=1 on a lane whose lane_done is set.
  - That write is dropped.
  - Sticky until err_clr; if set and clear occur in the same cycle, set wins.
- start is ignored in RUN and DONE.
- Lanes are fully independent; any mix of in_valid bits in the same cycle is legal.

Optional Feature:
Macro MEM_WRITE_D_PINGPONG_EN.
- Defined:
  - Bit ADDR_W-1 of wr_addr_bram is the write bank; bits ADDR_W-2:0 are (base+count) truncated.
  - The bank toggles in DONE; rd_bank = ~bank.
- Undefined:
  - The full ADDR_W is base+count; no bank bit; rd_bank is held at 0.

Decomposition:
- Package mem_write_d_pkg: FSM state enum (IDLE, RUN, DONE) and a localparam for the bank-bit index.
- One natural sub-module, mem_write_d_lane: the per-lane counter, done flag, overflow detect and output register. It is instantiated N1 times under a generate loop; the frame FSM stays in the top level.

Test Plan:
- Reset then start with cfg_len=4, cfg_base=0x010, all lanes valid for 4 cycles:
  - Each lane writes addrs 0x010..0x013 with matching data one cycle after request.
  - frame_done pulses once; busy drops; no error.
- Lanes finish at different times (lane0 valid continuously, lane3 valid every other cycle, cfg_len=3):
  - frame_done fires only after lane3's 3rd write.
  - Lane0's extra valid after its 3rd write is dropped and sets err_overflow.
- in_valid=1 in IDLE:
  - No wr_en_bram; err_overflow=1.
  - err_clr and a new violation in the same cycle leave it at 1; err_clr alone clears it.
- Ping-pong build, auto_restart=1, two frames with cfg_len=2, base=0:
  - Frame 1 addresses are 0x000, 0x001; frame 2 addresses are 0x800, 0x801.
  - rd_bank goes 1→0 at the first frame_done.
- cfg_base=0xFFE, cfg_len=4, non-ping-pong build:
  - Addresses are 0xFFE, 0xFFF, 0x000, 0x001 (wrap).
- Reset asserted mid-RUN after 2 of 4 writes:
  - All outputs are 0 immediately; no frame_done.
  - A new start then writes from the base again.
